// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator display path: converter FSM
// states, scan slot numbering (matches decoder anode order) and clamp limits.
package calc_disp_pkg;

  typedef enum logic [1:0] {IDLE, SAT, SHIFT, COMMIT} conv_state_t;

  localparam logic [1:0] IDX_THOU = 2'd1;
  localparam logic [1:0] IDX_HUND = 2'd0;
  localparam logic [1:0] IDX_TENS = 2'd3;
  localparam logic [1:0] IDX_ONES = 2'd2;

  localparam int POS_MAX = 9999;
  localparam int NEG_MAX = 99;

  // Picks the BCD nibble that belongs in a given scan slot.
  function automatic logic [3:0] slot_digit(input logic [1:0] idx, input logic [15:0] bcd);
    case (idx)
      IDX_THOU: return bcd[15:12];
      IDX_HUND: return bcd[11:8];
      IDX_TENS: return bcd[7:4];
      default:  return bcd[3:0];
    endcase
  endfunction

  function automatic logic [15:0] add3(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential signed-binary to BCD converter (saturate, then double-dabble).
// commit_en marks the final shift cycle, when bcd_next/neg_next/ovf_next are final.
module bin2bcd_seq
  import calc_disp_pkg::*;
#(
  parameter int DATA_W = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] value_in,
  input  logic                     value_valid,
  output logic                     value_ready,
  output logic                     commit_en,
  output logic [15:0]              bcd_next,
  output logic                     neg_next,
  output logic                     ovf_next,
  output logic                     done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  conv_state_t       state;
  logic [DATA_W-1:0] val_q;
  logic [DATA_W-1:0] mag_q;
  logic [15:0]       bcd_q;
  logic              neg_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              val_neg;
  logic [DATA_W-1:0] abs_val;
  logic [DATA_W-1:0] sat_mag;
  logic              sat_ovf;
  logic [15:0]       adj;
  logic [15:0]       shifted;

  // Unsigned negation keeps the most negative input exact as 2^(DATA_W-1).
  always_comb begin
    val_neg = val_q[DATA_W-1];
    abs_val = val_neg ? DATA_W'(-val_q) : val_q;
    sat_mag = abs_val;
    sat_ovf = 1'b0;
    if (!val_neg && int'(abs_val) > POS_MAX) begin
      sat_mag = DATA_W'(POS_MAX);
      sat_ovf = 1'b1;
    end else if (val_neg && int'(abs_val) > NEG_MAX) begin
      sat_mag = DATA_W'(NEG_MAX);
      sat_ovf = 1'b1;
    end
    adj       = add3(bcd_q);
    shifted   = {adj[14:0], mag_q[DATA_W-1]};
    commit_en = (state == SHIFT) && (cnt_q == CNT_W'(DATA_W - 1));
    bcd_next  = neg_q ? {8'd0, shifted[7:0]} : shifted;
    neg_next  = neg_q;
    ovf_next  = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      value_ready <= 1'b1;
      done        <= 1'b0;
      val_q       <= '0;
      mag_q       <= '0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (value_valid) begin
            val_q       <= value_in;
            value_ready <= 1'b0;
            state       <= SAT;
          end
        end
        SAT: begin
          neg_q <= val_neg;
          ovf_q <= sat_ovf;
          mag_q <= sat_mag;
          bcd_q <= '0;
          cnt_q <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          bcd_q <= shifted;
          mag_q <= mag_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (commit_en) begin
            done  <= 1'b1;
            state <= COMMIT;
          end
        end
        default: begin
          value_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Converts a signed result to BCD and time-multiplexes four digit slots toward
// the seven-segment decoder; displayed digits only change on a whole commit.
module display_scan_ctrl
  import calc_disp_pkg::*;
#(
  parameter int DATA_W      = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] value_in,
  input  logic                     value_valid,
  output logic                     value_ready,
  output logic                     conv_done,
  output logic                     ovf,
  output logic [1:0]               digit_idx,
  output logic [3:0]               digit_bcd,
  output logic                     is_neg
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic             commit_en;
  logic [15:0]      res_bcd;
  logic             res_neg;
  logic             res_ovf;
  logic [15:0]      shown_bcd;
  logic [CNT_W-1:0] ref_cnt;
  logic             wrap;
  logic [1:0]       idx_next;
  logic [15:0]      bcd_sel;

  bin2bcd_seq #(.DATA_W(DATA_W)) u_conv (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .commit_en   (commit_en),
    .bcd_next    (res_bcd),
    .neg_next    (res_neg),
    .ovf_next    (res_ovf),
    .done        (conv_done)
  );

  // Look ahead at the next slot and next digits so digit_bcd lands with digit_idx.
  always_comb begin
    wrap     = (ref_cnt == CNT_W'(REFRESH_DIV - 1));
    idx_next = wrap ? digit_idx + 2'd1 : digit_idx;
    bcd_sel  = commit_en ? res_bcd : shown_bcd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt   <= '0;
      digit_idx <= 2'd0;
      digit_bcd <= 4'd0;
      shown_bcd <= '0;
      is_neg    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ref_cnt   <= wrap ? '0 : ref_cnt + CNT_W'(1);
      digit_idx <= idx_next;
      digit_bcd <= slot_digit(idx_next, bcd_sel);
      if (commit_en) begin
        shown_bcd <= res_bcd;
        is_neg    <= res_neg;
        ovf       <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised bench for display_scan_ctrl: two instances (14-bit and 16-bit
// inputs) checked every cycle against a cycle-count/decimal-arithmetic model.
module tb_display_scan_ctrl;

  localparam int W0   = 14;
  localparam int W1   = 16;
  localparam int DIV0 = 4;
  localparam int DIV1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic mon_en;
  int   drv_val [2];
  logic vld [2];
  logic signed [W0-1:0] vin0;
  logic signed [W1-1:0] vin1;
  logic rdy [2], done_o [2], ovf_o [2], neg_o [2];
  logic [1:0] idx_o [2];
  logic [3:0] bcd_o [2];

  assign vin0 = W0'(drv_val[0]);
  assign vin1 = W1'(drv_val[1]);

  display_scan_ctrl #(.DATA_W(W0), .REFRESH_DIV(DIV0)) dut0 (
    .clk(clk), .rst_n(rst_n), .value_in(vin0), .value_valid(vld[0]),
    .value_ready(rdy[0]), .conv_done(done_o[0]), .ovf(ovf_o[0]),
    .digit_idx(idx_o[0]), .digit_bcd(bcd_o[0]), .is_neg(neg_o[0])
  );

  display_scan_ctrl #(.DATA_W(W1), .REFRESH_DIV(DIV1)) dut1 (
    .clk(clk), .rst_n(rst_n), .value_in(vin1), .value_valid(vld[1]),
    .value_ready(rdy[1]), .conv_done(done_o[1]), .ovf(ovf_o[1]),
    .digit_idx(idx_o[1]), .digit_bcd(bcd_o[1]), .is_neg(neg_o[1])
  );

  int checks = 0;
  int errors = 0;

  // Model state; digit places are 0=thousands 1=hundreds 2=tens 3=ones.
  int wd [2] = '{W0, W1};
  int dv [2] = '{DIV0, DIV1};
  int slot_place [4] = '{1, 0, 3, 2};
  int k [2];
  bit m_ready [2];
  int pend_edge [2];
  int p_dig [2][4];
  bit p_neg [2], p_ovf [2];
  int dig [2][4];
  bit m_neg [2], m_ovf [2], m_done [2];
  int mon_ei;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic computeExpected(input int d, input int v);
    int mag;
    bit n;
    n = (v < 0);
    mag = n ? -v : v;
    p_ovf[d] = 1'b0;
    if (!n && mag > 9999) begin mag = 9999; p_ovf[d] = 1'b1; end
    if (n && mag > 99) begin mag = 99; p_ovf[d] = 1'b1; end
    p_neg[d] = n;
    p_dig[d][0] = n ? 0 : mag / 1000;
    p_dig[d][1] = n ? 0 : (mag / 100) % 10;
    p_dig[d][2] = (mag / 10) % 10;
    p_dig[d][3] = mag % 10;
  endtask

  // Reference model: accept when idle, commit DATA_W+1 edges after the accept edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        k[d] = 0; m_ready[d] = 1'b1; pend_edge[d] = -10;
        m_neg[d] = 1'b0; m_ovf[d] = 1'b0; m_done[d] = 1'b0;
        for (int p = 0; p < 4; p++) dig[d][p] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        k[d]++;
        if (m_ready[d] && vld[d]) begin
          m_ready[d] = 1'b0;
          pend_edge[d] = k[d] + wd[d] + 1;
          computeExpected(d, drv_val[d]);
        end
        m_done[d] = 1'b0;
        if (k[d] == pend_edge[d]) begin
          for (int p = 0; p < 4; p++) dig[d][p] = p_dig[d][p];
          m_neg[d] = p_neg[d]; m_ovf[d] = p_ovf[d]; m_done[d] = 1'b1;
        end
        if (k[d] == pend_edge[d] + 1) m_ready[d] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      for (int d = 0; d < 2; d++) begin
        mon_ei = (k[d] / dv[d]) % 4;
        checkOutput($sformatf("idx%0d", d), int'(idx_o[d]), mon_ei);
        checkOutput($sformatf("bcd%0d", d), int'(bcd_o[d]), dig[d][slot_place[mon_ei]]);
        checkOutput($sformatf("neg%0d", d), int'(neg_o[d]), int'(m_neg[d]));
        checkOutput($sformatf("ovf%0d", d), int'(ovf_o[d]), int'(m_ovf[d]));
        checkOutput($sformatf("done%0d", d), int'(done_o[d]), int'(m_done[d]));
        checkOutput($sformatf("ready%0d", d), int'(rdy[d]), int'(m_ready[d]));
      end
    end
  end

  task automatic checkResetState(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_idx%0d", tag, d), int'(idx_o[d]), 0);
      checkOutput($sformatf("%s_bcd%0d", tag, d), int'(bcd_o[d]), 0);
      checkOutput($sformatf("%s_neg%0d", tag, d), int'(neg_o[d]), 0);
      checkOutput($sformatf("%s_ovf%0d", tag, d), int'(ovf_o[d]), 0);
      checkOutput($sformatf("%s_done%0d", tag, d), int'(done_o[d]), 0);
      checkOutput($sformatf("%s_ready%0d", tag, d), int'(rdy[d]), 1);
    end
  endtask

  // Called at a negedge; holds valid until the DUT takes the value.
  task automatic applyStimulus(input int d, input int v);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    drv_val[d] = v;
    vld[d] = 1'b1;
    while (!got && n < 200) begin
      if (rdy[d]) got = 1'b1;
      @(negedge clk);
      n++;
    end
    vld[d] = 1'b0;
    if (!got) checkOutput($sformatf("accept_timeout%0d", d), 0, 1);
  endtask

  task automatic waitIdle(input int d);
    int n;
    n = 0;
    while (!m_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4 * dv[d] + 1) @(negedge clk);
  endtask

  task automatic alignWrap(input int d);
    int n;
    n = 0;
    while (((k[d] + wd[d] + 2) % dv[d]) != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic randLoop(input int d, input int count);
    int v;
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 200)) - 100;
      else v = int'($urandom_range(0, (1 << wd[d]) - 1)) - (1 << (wd[d] - 1));
      applyStimulus(d, v);
      if ($urandom_range(0, 2) == 0) waitIdle(d);
      else repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    waitIdle(d);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    mon_en = 1'b0;
    for (int d = 0; d < 2; d++) begin drv_val[d] = 0; vld[d] = 1'b0; end
    repeat (2) @(negedge clk);
    checkResetState("rst_init");
    rst_n = 1'b1;
    mon_en = 1'b1;
    $display("[TB] directed conversions");
    applyStimulus(0, 1234);   waitIdle(0);
    applyStimulus(0, -57);    waitIdle(0);
    applyStimulus(0, -8192);  waitIdle(0);
    applyStimulus(0, 8191);   waitIdle(0);
    applyStimulus(0, 0);      waitIdle(0);
    applyStimulus(1, 12000);  waitIdle(1);
    applyStimulus(1, -32768); waitIdle(1);
    applyStimulus(1, 9999);   waitIdle(1);
    $display("[TB] busy ignore");
    applyStimulus(0, 42);
    repeat (3) @(negedge clk);
    applyStimulus(0, 77);
    waitIdle(0);
    $display("[TB] commit on slot wrap");
    alignWrap(0); applyStimulus(0, 5678);  waitIdle(0);
    alignWrap(1); applyStimulus(1, 4321);  waitIdle(1);
    alignWrap(0); applyStimulus(0, -3210); waitIdle(0);
    $display("[TB] random phase");
    fork
      randLoop(0, 25);
      randLoop(1, 25);
    join
    $display("[TB] reset mid-scan and mid-conversion");
    applyStimulus(0, 555);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetState("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    applyStimulus(0, 77); waitIdle(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
